control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: asynchronous reset, active-low.
REQ-003 SHALL have port IR, input, 32 bits: current instruction; opcode=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
REQ-004 SHALL have port Mem_ready, input, 1 bit: memory data valid on Mdatain this cycle.
REQ-005 SHALL have port PCout, output, 1 bit: drive PC onto bus.
REQ-006 SHALL have port PCin, output, 1 bit: load PC from bus.
REQ-007 SHALL have port IncPC, output, 1 bit: ALU computes PC+1.
REQ-008 SHALL have port MARin, output, 1 bit: load MAR.
REQ-009 SHALL have port MDRin, output, 1 bit: load MDR.
REQ-010 SHALL have port MDRout, output, 1 bit: drive MDR onto bus.
REQ-011 SHALL have port Read, output, 1 bit: MDR source select = memory.
REQ-012 SHALL have port IRin, output, 1 bit: load IR.
REQ-013 SHALL have port Yin, output, 1 bit: load Y.
REQ-014 SHALL have port Zin, output, 1 bit: load Z (low and high).
REQ-015 SHALL have port Zlowout, output, 1 bit: drive Z[31:0] onto bus.
REQ-016 SHALL have port Cout, output, 1 bit: drive sign-extended IR[18:0] onto bus.
REQ-017 SHALL have port Gra, output, 1 bit: register select = ra.
REQ-018 SHALL have port Grb, output, 1 bit: register select = rb.
REQ-019 SHALL have port Grc, output, 1 bit: register select = rc.
REQ-020 SHALL have port Rin, output, 1 bit: write selected register.
REQ-021 SHALL have port Rout, output, 1 bit: drive selected register onto bus.
REQ-022 SHALL have port operation, output, 4 bits: ALU operation code.
REQ-023 SHALL have port Run, output, 1 bit: high while sequencing, low in RST and HALT.
REQ-024 SHALL have port state, output, 4 bits: RST=0, T0=1, T1=2, WAIT=3, T2=4, T3=5, T4=6, T5=7, HALT=8.

Function
REQ-025 SHALL be a Moore FSM: outputs decoded from the registered state and IR only; unlisted strobes are 0 and operation is 0000 in every state.
REQ-026 SHALL sequence RST->T0 unconditionally on the first rising edge after reset release.
REQ-027 SHALL assert in T0: PCout, MARin, IncPC, Zin; T0->T1.
REQ-028 SHALL assert in T1: Zlowout, PCin, Read, MDRin; T1->T2 if Mem_ready=1, else T1->WAIT.
REQ-029 SHALL assert in WAIT: Read, MDRin only; stay while Mem_ready=0, WAIT->T2 when Mem_ready=1; PCin is never asserted in WAIT.
REQ-030 SHALL assert in T2: MDRout, IRin; T2->T3.
REQ-031 SHALL decode opcode in T3: add 00000, sub 00001, and 00010, or 00011, shr 00100, shl 00101, ror 00110, rol 00111, addi 01000, andi 01001, ori 01010, neg 01011, not 01100, nop 01101, halt 01110; all others are treated as nop.
REQ-032 SHALL map operation: opcodes 00000-00111 -> opcode[3:0]; addi 0000, andi 0010, ori 0011, neg 1011, not 1100.
REQ-033 SHALL, for 3-register ops, assert T3: Grb, Rout, Yin; T4: Grc, Rout, Zin, operation; T5: Zlowout, Gra, Rin; T5->T0.
REQ-034 SHALL, for immediate ops, assert T3: Grb, Rout, Yin; T4: Cout, Zin, operation; T5: Zlowout, Gra, Rin; T5->T0.
REQ-035 SHALL, for neg/not, assert T3: Grb, Rout, Zin, operation; T4: Zlowout, Gra, Rin; T4->T0, T5 skipped.
REQ-036 SHALL, for nop/illegal, assert nothing in T3; T3->T0.
REQ-037 SHALL, for halt, go T3->HALT; HALT holds with all strobes 0 until clear is asserted.

Reset
REQ-038 SHALL, while clear=0, force state=RST and all outputs to 0 immediately, regardless of Clock, including mid-instruction and in WAIT or HALT.
REQ-039 SHALL leave datapath register contents to the datapath; no strobe glitches high during reset.

Verification
REQ-040 IR=0x10918000 (and R1,R2,R3), Mem_ready=1 -> states 1,2,4,5,6,7,1; T4 asserts Grc,Rout,Zin with operation=0010; T5 asserts Gra,Rin.
REQ-041 Mem_ready=0 for the first 3 fetch cycles -> T1, WAIT, WAIT, then T2 on the 4th cycle (Mem_ready=1 in WAIT); PCin high exactly one cycle.
REQ-042 IR=0x40918005 (addi R1,R2,5) -> T4 asserts Cout,Zin with operation=0000; Yin asserted only in T3.
REQ-043 IR=0x58900000 (neg R1,R2) -> T3 asserts Zin with operation=1011; T4 asserts Gra,Rin; next state T0, T5 never visited.
REQ-044 IR=0x70000000 (halt) -> state=8, Run=0, no strobes for 20 cycles; clear pulse low -> state=0, then T0.
REQ-045 clear driven low in T4 mid-cycle -> all outputs 0 and state=0 before the next Clock edge; after release, RST->T0.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer for a simple load/store CPU.
// It fetches through T0..T2 (with memory wait) and executes ALU, immediate, unary, nop and halt instructions.
module control_sequencer (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [3:0]  operation,
  output logic        Run,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StWait = 4'd3,
    StT2   = 4'd4,
    StT3   = 4'd5,
    StT4   = 4'd6,
    StT5   = 4'd7,
    StHalt = 4'd8
  } state_e;

  state_e state_q, state_d;

  logic [4:0] opcode;
  logic       is_3reg, is_imm, is_unary, is_halt;
  logic [3:0] alu_op;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_3reg   = (opcode[4:3] == 2'b00);
  assign is_imm    = (opcode == 5'b01000) || (opcode == 5'b01001) || (opcode == 5'b01010);
  assign is_unary  = (opcode == 5'b01011) || (opcode == 5'b01100);
  assign is_halt   = (opcode == 5'b01110);

  always_comb begin
    alu_op = 4'b0000;
    if (is_3reg) begin
      alu_op = opcode[3:0];
    end else begin
      case (opcode)
        5'b01001: alu_op = 4'b0010;
        5'b01010: alu_op = 4'b0011;
        5'b01011: alu_op = 4'b1011;
        5'b01100: alu_op = 4'b1100;
        default:  alu_op = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d   = state_q;
    PCout     = 1'b0;
    PCin      = 1'b0;
    IncPC     = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Read      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Cout      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Grc       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    operation = 4'b0000;
    Run       = (state_q != StRst) && (state_q != StHalt);

    case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = Mem_ready ? StT2 : StWait;
      end
      // PC was already loaded in T1, so WAIT only keeps the memory read going.
      StWait: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (Mem_ready) state_d = StT2;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (is_3reg || is_imm) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (is_unary) begin
          Grb       = 1'b1;
          Rout      = 1'b1;
          Zin       = 1'b1;
          operation = alu_op;
          state_d   = StT4;
        end else if (is_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StT0;
        end
      end
      StT4: begin
        if (is_unary) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = StT0;
        end else if (is_3reg) begin
          Grc       = 1'b1;
          Rout      = 1'b1;
          Zin       = 1'b1;
          operation = alu_op;
          state_d   = StT5;
        end else if (is_imm) begin
          Cout      = 1'b1;
          Zin       = 1'b1;
          operation = alu_op;
          state_d   = StT5;
        end else begin
          state_d = StT0;
        end
      end
      StT5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = StT0;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

endmodule
